// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the sys_ctrl_mw command controller.
// Optional error responses are enabled by defining SYS_CTRL_ERR_RESP_EN.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_ADDR,
        S_W_DATA,
        S_R_ADDR,
        S_R_WAIT,
        S_OP_A,
        S_OP_B,
        S_FUN,
        S_ALU_WAIT,
        S_TX_PUSH
    } state_e;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] ERR_CODE    = 8'hEE;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // Width of a counter that must hold the value n (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sys_ctrl_mw_resp_serializer.sv
// Response serializer: loads up to NW words and streams them LSB word first
// into the TX FIFO, stalling on full; done_o marks the cycle the last word goes out.
module resp_serializer
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NW         = 2,
    parameter int CW         = cnt_width(NW)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           load_i,
    input  logic [NW-1:0][DATA_WIDTH-1:0]  words_i,
    input  logic [CW-1:0]                  nwords_i,
    input  logic                           full_i,
    output logic                           wr_req_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           done_o
);

    logic                          act_q, act_d;
    logic [CW-1:0]                 rem_q, rem_d;
    logic [NW-1:0][DATA_WIDTH-1:0] buf_q, buf_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q <= 1'b0;
            rem_q <= '0;
            buf_q <= '0;
        end else begin
            act_q <= act_d;
            rem_q <= rem_d;
            buf_q <= buf_d;
        end
    end

    // The buffer shifts down one word per write, so the head is always word 0.
    always_comb begin
        act_d    = act_q;
        rem_d    = rem_q;
        buf_d    = buf_q;
        wr_req_o = act_q && !full_i;
        done_o   = wr_req_o && (rem_q == CW'(1));
        if (load_i) begin
            act_d = 1'b1;
            rem_d = nwords_i;
            buf_d = words_i;
        end else if (wr_req_o) begin
            buf_d = buf_q >> DATA_WIDTH;
            rem_d = rem_q - CW'(1);
            if (done_o) act_d = 1'b0;
        end
    end

    assign data_o = buf_q[0];

endmodule

// File: rtl/sys_ctrl_mw.sv
// Unified system controller: decodes UART command frames, drives regfile/ALU,
// and returns responses through the TX FIFO. Macro: SYS_CTRL_ERR_RESP_EN.
module sys_ctrl_mw
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4,
    parameter int TIMEOUT_CYC   = 255
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    Rd_data,
    input  logic                     Rd_data_valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_valid,
    input  logic                     Full,
    output logic [DATA_WIDTH-1:0]    FIFO_IN,
    output logic                     Wr_Req,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     ALU_EN,
    output logic                     Gate_en,
    output logic                     CLK_Div_EN,
    output logic                     Busy,
    output logic                     Timeout
);

    localparam int NW = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int CW = cnt_width(NW);
    localparam int TW = cnt_width(TIMEOUT_CYC);

    localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(CMD_WR);
    localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(CMD_RD);
    localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(CMD_ALU_OP);
    localparam logic [DATA_WIDTH-1:0] OP_NOP = DATA_WIDTH'(CMD_ALU_NOP);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [FUN_WIDTH-1:0]    fun_q, fun_d;
    logic                    wren_q, wren_d;
    logic                    rden_q, rden_d;
    logic                    aluen_q, aluen_d;
    logic                    gate_q, gate_d;
    logic                    tmo_q, tmo_d;
    logic                    div_q;
    logic [TW-1:0]           tcnt_q, tcnt_d;

    logic                          ld;
    logic [NW-1:0][DATA_WIDTH-1:0] ld_words;
    logic [CW-1:0]                 ld_n;
    logic                          ser_done;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            fun_q   <= '0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            aluen_q <= 1'b0;
            gate_q  <= 1'b0;
            tmo_q   <= 1'b0;
            div_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fun_q   <= fun_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            aluen_q <= aluen_d;
            gate_q  <= gate_d;
            tmo_q   <= tmo_d;
            div_q   <= 1'b1;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fun_d    = fun_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        aluen_d  = 1'b0;
        gate_d   = gate_q;
        tmo_d    = 1'b0;
        tcnt_d   = tcnt_q;
        ld       = 1'b0;
        ld_words = '0;
        ld_n     = '0;
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        OP_WR:  state_d = S_W_ADDR;
                        OP_RD:  state_d = S_R_ADDR;
                        OP_ALU: begin state_d = S_OP_A; gate_d = 1'b1; end
                        OP_NOP: begin state_d = S_FUN;  gate_d = 1'b1; end
                        default: begin
`ifdef SYS_CTRL_ERR_RESP_EN
                            ld          = 1'b1;
                            ld_words[0] = DATA_WIDTH'(ERR_CODE);
                            ld_n        = CW'(1);
                            state_d     = S_TX_PUSH;
`endif
                        end
                    endcase
                end
            end
            S_W_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = S_W_DATA;
            end
            S_W_DATA: if (RX_D_VLD) begin
                wdata_d = RX_P_DATA;
                wren_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_R_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                rden_d  = 1'b1;
                tcnt_d  = '0;
                state_d = S_R_WAIT;
            end
            S_OP_A: if (RX_D_VLD) begin
                addr_d  = ADDR_WIDTH'(OPA_ADDR);
                wdata_d = RX_P_DATA;
                wren_d  = 1'b1;
                state_d = S_OP_B;
            end
            S_OP_B: if (RX_D_VLD) begin
                addr_d  = ADDR_WIDTH'(OPB_ADDR);
                wdata_d = RX_P_DATA;
                wren_d  = 1'b1;
                state_d = S_FUN;
            end
            S_FUN: if (RX_D_VLD) begin
                fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
                aluen_d = 1'b1;
                tcnt_d  = '0;
                state_d = S_ALU_WAIT;
            end
            S_R_WAIT, S_ALU_WAIT: begin
                // A valid on the final wait cycle beats the timeout.
                if (state_q == S_R_WAIT && Rd_data_valid) begin
                    ld          = 1'b1;
                    ld_words[0] = Rd_data;
                    ld_n        = CW'(1);
                    state_d     = S_TX_PUSH;
                end else if (state_q == S_ALU_WAIT && ALU_OUT_valid) begin
                    ld       = 1'b1;
                    ld_words = ALU_OUT;
                    ld_n     = CW'(NW);
                    gate_d   = 1'b0;
                    state_d  = S_TX_PUSH;
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_d  = 1'b1;
                    gate_d = 1'b0;
`ifdef SYS_CTRL_ERR_RESP_EN
                    ld          = 1'b1;
                    ld_words[0] = DATA_WIDTH'(ERR_CODE);
                    ld_n        = CW'(1);
                    state_d     = S_TX_PUSH;
`else
                    state_d     = S_IDLE;
`endif
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_TX_PUSH: if (ser_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    resp_serializer #(
        .DATA_WIDTH(DATA_WIDTH),
        .NW        (NW),
        .CW        (CW)
    ) u_ser (
        .clk_i   (CLK),
        .rst_i   (rst),
        .load_i  (ld),
        .words_i (ld_words),
        .nwords_i(ld_n),
        .full_i  (Full),
        .wr_req_o(Wr_Req),
        .data_o  (FIFO_IN),
        .done_o  (ser_done)
    );

    assign WrEn       = wren_q;
    assign RdEn       = rden_q;
    assign Address    = addr_q;
    assign WrData     = wdata_q;
    assign ALU_FUN    = fun_q;
    assign ALU_EN     = aluen_q;
    assign Gate_en    = gate_q;
    assign CLK_Div_EN = div_q;
    assign Timeout    = tmo_q;
    assign Busy       = (state_q != S_IDLE);

endmodule

// File: doc/sys_ctrl_mw.md
Name: sys_ctrl_mw

Overview:
- Unified, parametrised system controller: a single FSM decodes command frames from the UART RX path and drives the register file, ALU and clock gate.
- Read results and multi-word ALU results are serialised into the TX FIFO, with Full back-pressure and a response timeout.
- Sits between UART RX/TX-FIFO and RegFile/ALU. Replaces the split RX/TX controller pair.

Parameters:
- DATA_WIDTH, 8, width of RX frames, register data and FIFO words
- ADDR_WIDTH, 4, register file address width
- ALU_OUT_WIDTH, 16, ALU result width; must be an integer multiple of DATA_WIDTH
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYC, 255, maximum wait cycles for Rd_data_valid or ALU_OUT_valid

Ports:
- CLK  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received frame
- RX_D_VLD  in  1  frame valid, 1-cycle pulse
- Rd_data  in  DATA_WIDTH  register file read data
- Rd_data_valid  in  1  read data valid
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_valid  in  1  ALU result valid
- Full  in  1  TX FIFO full
- FIFO_IN  out  DATA_WIDTH  TX FIFO write data
- Wr_Req  out  1  TX FIFO write strobe
- WrEn  out  1  register write pulse
- RdEn  out  1  register read pulse
- Address  out  ADDR_WIDTH  register address
- WrData  out  DATA_WIDTH  register write data
- ALU_FUN  out  FUN_WIDTH  ALU function
- ALU_EN  out  1  ALU start pulse
- Gate_en  out  1  ALU clock gate enable
- CLK_Div_EN  out  1  clock divider enable
- Busy  out  1  high in every state except IDLE
- Timeout  out  1  1-cycle pulse when a wait times out

Behaviour:
- Reset: all outputs 0; FSM in IDLE; response index and timeout counter cleared.
- CLK_Div_EN: registered 1 from the first clock edge after rst deasserts.
- Frame acceptance: frames are consumed only on RX_D_VLD.
- Frames arriving in R_WAIT, ALU_WAIT or TX_PUSH are silently dropped.
- Opcodes, decoded in IDLE (DATA_WIDTH LSBs):
  - 0xAA: write. IDLE -> W_ADDR -> W_DATA. On the data frame, pulse WrEn for 1 cycle with the latched Address and WrData = frame; return to IDLE.
  - 0xBB: read. IDLE -> R_ADDR. On the addr frame, pulse RdEn for 1 cycle; go to R_WAIT. On Rd_data_valid, capture Rd_data as a 1-word response; go to TX_PUSH.
  - 0xCC: ALU with operands. IDLE -> OP_A -> OP_B -> FUN.
    - OP_A frame: WrEn pulse, Address=0. OP_B frame: WrEn pulse, Address=1.
    - FUN frame: ALU_EN pulse, ALU_FUN = frame[FUN_WIDTH-1:0]; go to ALU_WAIT.
  - 0xDD: ALU without operands. IDLE -> FUN, then as 0xCC.
  - Any other value: stays in IDLE (see optional feature).
- Address capture: latched from frame[ADDR_WIDTH-1:0]; upper bits ignored.
- Gate_en: set on entry to OP_A or FUN; cleared on the cycle after ALU_OUT_valid, on timeout, or on reset.
- ALU_WAIT: on ALU_OUT_valid, capture ALU_OUT as NW = ALU_OUT_WIDTH/DATA_WIDTH words; go to TX_PUSH.
- TX_PUSH:
  - Each cycle with !Full: Wr_Req=1 and FIFO_IN = word[idx], LSB word first; idx increments.
  - Full=1 stalls; Wr_Req=0 and idx is held.
  - After the last word, return to IDLE (same cycle that word is written).
- Timeout: counter runs in R_WAIT and ALU_WAIT. Reaching TIMEOUT_CYC with no valid pulses Timeout and returns to IDLE; nothing is pushed.
- Valid vs timeout: a valid arriving on the same cycle as the count limit wins.
- Latency: read response Wr_Req is asserted 1 cycle after Rd_data_valid (if !Full). The first ALU word follows ALU_OUT_valid by 1 cycle.
- Reset mid-operation: FSM aborts immediately; partially pushed responses are not resumed.

Optional Feature:
- Macro: SYS_CTRL_ERR_RESP_EN.
- Defined: an unknown opcode in IDLE enters TX_PUSH with a 1-word response 0xEE (zero-extended/truncated to DATA_WIDTH). A timeout also pushes 0xEE after pulsing Timeout.
- Undefined: unknown opcodes and timeouts produce no FIFO writes.

Decomposition:
- Package sys_ctrl_pkg holds:
  - state enum
  - opcode constants CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - ERR_CODE=0xEE
  - operand addresses OPA_ADDR=0, OPB_ADDR=1
- Sub-module resp_serializer: loads N words, streams them to the FIFO with Full back-pressure, flags done.

Test Plan:
- Write: frames AA,05,3C -> one WrEn pulse, Address=5, WrData=0x3C; Busy low afterwards.
- Read with back-pressure: frames BB,05; Rd_data=0x3C valid; Full held high 3 cycles -> Wr_Req exactly once, after Full drops, FIFO_IN=0x3C.
- ALU with operands: frames CC,12,34,02; ALU_OUT=0xABCD valid -> WrEn to addr 0 (0x12) and addr 1 (0x34); ALU_EN with ALU_FUN=2; FIFO writes 0xCD then 0xAB; Gate_en low after.
- Timeout: frames DD,01 with ALU_OUT_valid never asserted -> Timeout pulse TIMEOUT_CYC cycles after ALU_EN; return to IDLE; no FIFO write, or 0xEE with SYS_CTRL_ERR_RESP_EN.
- Robustness: unknown opcode 0x55, then a frame injected during ALU_WAIT, then rst asserted mid TX_PUSH.
  - Unknown opcode is ignored, or answered with 0xEE when the feature is on.
  - Injected frame is dropped.
  - rst clears all outputs asynchronously; the next AA command operates normally.
